// File: rtl/ram_port_arbiter_pkg.sv
// rtl/ram_port_arbiter_pkg.sv - shared constants for the image RAM arbiter
// Purpose: grant encoding and default geometry shared with the UART image
//          writer and the TFT controller.
// Ports:   none (package).
package ram_port_arbiter_pkg;

    localparam int DEF_AW        = 16;
    localparam int DEF_DW        = 16;
    localparam int DEF_IMG_WORDS = 16384;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2
    } grant_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - bus bundle between requesters, arbiter and RAM
// Purpose: groups the write stream, read handshake, RAM port and status flags.
// Ports:   master - requesters/RAM side (drives wr_*, rd_req/rd_addr, ram_dout)
//          slave  - arbiter side (drives rd_ack/rd_valid/rd_data, ram_*, flags)
interface ram_port_arbiter_if
    import ram_port_arbiter_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ack;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          wr_overflow;
    logic          frame_done;

    modport master (
        output wr_en, wr_addr, wr_data, rd_req, rd_addr, ram_dout,
        input  rd_ack, rd_valid, rd_data, ram_en, ram_we, ram_addr, ram_din,
               wr_overflow, frame_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_req, rd_addr, ram_dout,
        output rd_ack, rd_valid, rd_data, ram_en, ram_we, ram_addr, ram_din,
               wr_overflow, frame_done
    );

endinterface

// File: rtl/ram_port_arbiter_sync_wr_fifo.sv
// rtl/ram_port_arbiter_sync_wr_fifo.sv - synchronous FIFO used as write buffer
// Purpose: DEPTH x WIDTH FIFO (DEPTH power of two, >= 2) with simultaneous
//          push/pop; a push while full is accepted only if a pop frees a slot.
// Ports:   i_clk, i_rst (async, active-high)
//          i_push, i_push_data - write side
//          i_pop, o_head       - read side, o_head is the current head entry
//          o_full, o_empty     - occupancy flags
module sync_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int            PW     = $clog2(DEPTH);
    localparam logic [PW:0]   L_FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;

    logic w_pop_ok;
    logic w_push_ok;

    assign o_full    = (r_count == L_FULL);
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take it.
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - single-port image RAM arbiter (display read vs UART write)
// Purpose: buffers UART pixel writes, gives TFT reads priority, forces a write
//          through after MAX_WAIT lost cycles, counts committed frame words.
// Ports:   i_clk, i_rst (async, active-high)
//          io_bus (slave modport) - write stream, read handshake, RAM port,
//          wr_overflow (sticky) and frame_done (pulse).
// Build option: RAM_OUT_REG_EN - RAM output register in use, rd_valid comes
//          2 cycles after the read command instead of 1.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int AW            = DEF_AW,
    parameter int DW            = DEF_DW,
    parameter int WR_FIFO_DEPTH = 4,
    parameter int MAX_WAIT      = 8,
    parameter int IMG_WORDS     = DEF_IMG_WORDS
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    ram_port_arbiter_if.slave    io_bus
);

    localparam int               WCW         = $clog2(MAX_WAIT + 1);
    localparam int               FCW         = (IMG_WORDS > 1) ? $clog2(IMG_WORDS) : 1;
    localparam logic [WCW-1:0]   L_MAX_WAIT  = WCW'(MAX_WAIT);
    localparam logic [FCW-1:0]   L_LAST_WORD = FCW'(IMG_WORDS - 1);

    logic [AW+DW-1:0] w_fifo_head;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_pop;
    logic             w_drop;
    grant_t           w_grant;

    logic             r_ram_en;
    logic             r_ram_we;
    logic [AW-1:0]    r_ram_addr;
    logic [DW-1:0]    r_ram_din;
    logic             r_rd_ack;
    logic             r_rd_valid;
    logic [DW-1:0]    r_rd_hold;
    logic             r_wr_overflow;
    logic             r_frame_done;
    logic [WCW-1:0]   r_wait_cnt;
    logic [FCW-1:0]   r_frame_cnt;
`ifdef RAM_OUT_REG_EN
    logic             r_rd_stage;
`endif

    sync_wr_fifo #(
        .DEPTH (WR_FIFO_DEPTH),
        .WIDTH (AW + DW)
    ) u_wr_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (io_bus.wr_en),
        .i_push_data ({io_bus.wr_addr, io_bus.wr_data}),
        .i_pop       (w_pop),
        .o_head      (w_fifo_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // Starved write first, then display read, then any queued write.
    always_comb begin
        w_grant = GNT_NONE;
        if (!w_fifo_empty && (r_wait_cnt >= L_MAX_WAIT)) begin
            w_grant = GNT_WR;
        end else if (io_bus.rd_req) begin
            w_grant = GNT_RD;
        end else if (!w_fifo_empty) begin
            w_grant = GNT_WR;
        end
    end

    assign w_pop  = (w_grant == GNT_WR);
    assign w_drop = io_bus.wr_en && w_fifo_full && !w_pop;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ram_en      <= 1'b0;
            r_ram_we      <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_din     <= '0;
            r_rd_ack      <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_rd_hold     <= '0;
            r_wr_overflow <= 1'b0;
            r_frame_done  <= 1'b0;
            r_wait_cnt    <= '0;
            r_frame_cnt   <= '0;
`ifdef RAM_OUT_REG_EN
            r_rd_stage    <= 1'b0;
`endif
        end else begin
            r_ram_en     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_rd_ack     <= 1'b0;
            r_frame_done <= 1'b0;

            unique case (w_grant)
                GNT_RD: begin
                    r_ram_en   <= 1'b1;
                    r_ram_addr <= io_bus.rd_addr;
                    r_rd_ack   <= 1'b1;
                end
                GNT_WR: begin
                    r_ram_en   <= 1'b1;
                    r_ram_we   <= 1'b1;
                    r_ram_addr <= w_fifo_head[AW+DW-1:DW];
                    r_ram_din  <= w_fifo_head[DW-1:0];
                    if (r_frame_cnt == L_LAST_WORD) begin
                        r_frame_cnt  <= '0;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_frame_cnt  <= r_frame_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase

            if (w_fifo_empty || w_pop) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != L_MAX_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            if (w_drop) begin
                r_wr_overflow <= 1'b1;
            end

            // r_rd_ack marks the cycle the read command sits on the RAM port.
`ifdef RAM_OUT_REG_EN
            r_rd_stage <= r_rd_ack;
            r_rd_valid <= r_rd_stage;
`else
            r_rd_valid <= r_rd_ack;
`endif
            if (r_rd_valid) begin
                r_rd_hold <= io_bus.ram_dout;
            end
        end
    end

    // The RAM presents its word during the rd_valid cycle; the hold register
    // keeps it visible until the next read returns.
    assign io_bus.rd_data     = r_rd_valid ? io_bus.ram_dout : r_rd_hold;
    assign io_bus.rd_valid    = r_rd_valid;
    assign io_bus.rd_ack      = r_rd_ack;
    assign io_bus.ram_en      = r_ram_en;
    assign io_bus.ram_we      = r_ram_we;
    assign io_bus.ram_addr    = r_ram_addr;
    assign io_bus.ram_din     = r_ram_din;
    assign io_bus.wr_overflow = r_wr_overflow;
    assign io_bus.frame_done  = r_frame_done;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int MAXW  = 8;
    localparam int IMG   = 4;
`ifdef RAM_OUT_REG_EN
    localparam int LAT   = 2;
`else
    localparam int LAT   = 1;
`endif

    logic clk;
    logic rst;
    logic ram_clr;
    int   checks;
    int   errors;
    int   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    ram_port_arbiter #(
        .AW            (AW),
        .DW            (DW),
        .WR_FIFO_DEPTH (DEPTH),
        .MAX_WAIT      (MAXW),
        .IMG_WORDS     (IMG)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    function automatic logic [15:0] pat(input logic [15:0] a);
        return {a[7:0] ^ 8'hA5, a[15:8] ^ 8'h3C};
    endfunction

    // Synchronous single-port RAM, 1-cycle read latency plus optional output reg.
    logic [15:0] ram_mem [0:65535];
    logic        ram_wr  [0:65535];
    logic [15:0] ram_q;
    logic [15:0] ram_q2;
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 65536; i++) ram_wr[i] <= 1'b0;
        end else if (bus.ram_en) begin
            if (bus.ram_we) begin
                ram_mem[bus.ram_addr] <= bus.ram_din;
                ram_wr[bus.ram_addr]  <= 1'b1;
            end else begin
                ram_q <= ram_wr[bus.ram_addr] ? ram_mem[bus.ram_addr] : pat(bus.ram_addr);
            end
        end
        ram_q2 <= ram_q;
    end
`ifdef RAM_OUT_REG_EN
    assign bus.ram_dout = ram_q2;
`else
    assign bus.ram_dout = ram_q;
`endif

    // Reference model: queue of pending writes, wait counter, issued-word count.
    typedef struct packed { logic [15:0] a; logic [15:0] d; } wr_t;
    typedef struct { int due; logic [15:0] d; } rd_t;
    wr_t         mq[$];
    rd_t         rq[$];
    logic [15:0] mdl_mem [int];
    int          m_wait;
    int          m_issued;
    logic        pw_valid;
    logic [15:0] pw_a, pw_d;
    logic        e_en, e_we, e_ack, e_valid, e_ovf, e_fd;
    logic [15:0] e_addr, e_din, e_rdata;

    function automatic logic [15:0] mread(input logic [15:0] a);
        if (mdl_mem.exists(int'(a))) return mdl_mem[int'(a)];
        return pat(a);
    endfunction

    function automatic logic [53:0] dut_vec();
        return {bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_din, bus.rd_ack,
                bus.rd_valid, bus.rd_data, bus.wr_overflow, bus.frame_done};
    endfunction

    function automatic logic [53:0] exp_vec();
        return {e_en, e_we, e_addr, e_din, e_ack, e_valid, e_rdata, e_ovf, e_fd};
    endfunction

    task automatic clear_model();
        mq.delete();
        rq.delete();
        m_wait = 0; m_issued = 0; pw_valid = 1'b0;
        e_en = 0; e_we = 0; e_ack = 0; e_valid = 0; e_ovf = 0; e_fd = 0;
        e_addr = '0; e_din = '0; e_rdata = '0;
    endtask

    // Advance one clock: predict from the spec rules, then sample #1 after the edge.
    task automatic tick();
        int  g;
        bit  nonempty;
        wr_t h;
        if (pw_valid) begin mdl_mem[int'(pw_a)] = pw_d; pw_valid = 1'b0; end
        nonempty = (mq.size() > 0);
        g = 0;
        if (nonempty && m_wait >= MAXW) g = 2;
        else if (bus.rd_req)            g = 1;
        else if (nonempty)              g = 2;
        if (!nonempty || g == 2) m_wait = 0;
        else if (m_wait < MAXW)  m_wait++;
        e_en = 0; e_we = 0; e_ack = 0; e_fd = 0;
        if (g == 1) begin
            e_en = 1; e_addr = bus.rd_addr; e_ack = 1;
            rq.push_back('{cyc + 1 + LAT, mread(bus.rd_addr)});
        end else if (g == 2) begin
            h = mq.pop_front();
            e_en = 1; e_we = 1; e_addr = h.a; e_din = h.d;
            pw_valid = 1'b1; pw_a = h.a; pw_d = h.d;
            e_fd = ((m_issued % IMG) == IMG - 1);
            m_issued++;
        end
        if (bus.wr_en) begin
            if (mq.size() >= DEPTH) e_ovf = 1;
            else mq.push_back({bus.wr_addr, bus.wr_data});
        end
        @(posedge clk); #1;
        cyc++;
        e_valid = 0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            e_valid = 1; e_rdata = rq[0].d; rq.delete(0);
        end
    endtask

    task automatic drive_idle();
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_req = 0; bus.rd_addr = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        ram_clr = 1'b1;
        rst = 1'b1;
        clear_model();
        @(posedge clk); #1;
        checks++;
        if (dut_vec() !== 54'd0) begin errors++;
            $display("FAIL reset_outputs got=%h expected=0", dut_vec()); end
        @(posedge clk); #1;
        ram_clr = 1'b0;
        rst = 1'b0;
        repeat (2) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin errors++;
                $display("FAIL reset_idle cyc=%0d got=%h expected=%h", cyc, dut_vec(), exp_vec()); end
        end
    endtask

    task automatic test_single_write();
        bus.wr_en = 1; bus.wr_addr = 16'h0010; bus.wr_data = 16'hABCD;
        tick();
        bus.wr_en = 0;
        checks++;
        if (bus.ram_en !== 1'b0) begin errors++;
            $display("FAIL single_write_push got ram_en=%b expected 0", bus.ram_en); end
        tick();
        checks++;
        if ({bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_din} !== {2'b11, 16'h0010, 16'hABCD}) begin errors++;
            $display("FAIL single_write_cmd got en=%b we=%b addr=%h din=%h expected 1 1 0010 abcd",
                     bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_din); end
        tick();
        checks++;
        if (dut_vec() !== exp_vec()) begin errors++;
            $display("FAIL single_write_idle got=%h expected=%h", dut_vec(), exp_vec()); end
    endtask

    task automatic test_starvation();
        int reads;
        bit done;
        reads = 0; done = 0;
        bus.rd_req = 1; bus.rd_addr = 16'h0040;
        bus.wr_en = 1; bus.wr_addr = 16'h0041; bus.wr_data = 16'h5555;
        tick();
        bus.wr_en = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin errors++;
                $display("FAIL starvation_vec cyc=%0d got=%h expected=%h", cyc, dut_vec(), exp_vec()); end
            if (bus.ram_we) done = 1;
            else if (bus.rd_ack) reads++;
        end
        checks++;
        if (!done || reads != MAXW) begin errors++;
            $display("FAIL starvation_reads got=%0d (write seen %0d) expected=%0d", reads, done, MAXW); end
        tick();
        checks++;
        if ({bus.rd_ack, bus.ram_we} !== 2'b10) begin errors++;
            $display("FAIL starvation_resume got ack=%b we=%b expected 1 0", bus.rd_ack, bus.ram_we); end
        bus.rd_req = 0;
        repeat (3) tick();
    endtask

    task automatic test_overflow();
        int writes;
        do_reset();
        writes = 0;
        bus.rd_req = 1; bus.rd_addr = 16'h0002;
        for (int i = 0; i < 5; i++) begin
            bus.wr_en = 1; bus.wr_addr = 16'(16'h0020 + i); bus.wr_data = 16'($urandom);
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin errors++;
                $display("FAIL overflow_fill cyc=%0d got=%h expected=%h", cyc, dut_vec(), exp_vec()); end
        end
        bus.wr_en = 0; bus.rd_req = 0;
        checks++;
        if (bus.wr_overflow !== 1'b1) begin errors++;
            $display("FAIL overflow_flag got=%b expected=1", bus.wr_overflow); end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.ram_we) writes++;
            checks++;
            if (dut_vec() !== exp_vec()) begin errors++;
                $display("FAIL overflow_drain cyc=%0d got=%h expected=%h", cyc, dut_vec(), exp_vec()); end
        end
        checks++;
        if (writes != DEPTH || bus.wr_overflow !== 1'b1) begin errors++;
            $display("FAIL overflow_sticky got writes=%0d flag=%b expected writes=%0d flag=1",
                     writes, bus.wr_overflow, DEPTH); end
        do_reset();
        checks++;
        if (bus.wr_overflow !== 1'b0) begin errors++;
            $display("FAIL overflow_cleared got=%b expected=0", bus.wr_overflow); end
    endtask

    task automatic test_read_latency();
        bus.wr_en = 1; bus.wr_addr = 16'h0100; bus.wr_data = 16'h1234;
        tick();
        bus.wr_en = 0;
        repeat (2) tick();
        bus.rd_req = 1; bus.rd_addr = 16'h0100;
        tick();
        bus.rd_req = 0;
        checks++;
        if ({bus.rd_ack, bus.ram_en, bus.ram_we, bus.ram_addr} !== {3'b110, 16'h0100}) begin errors++;
            $display("FAIL read_cmd got ack=%b en=%b we=%b addr=%h expected 1 1 0 0100",
                     bus.rd_ack, bus.ram_en, bus.ram_we, bus.ram_addr); end
        for (int i = 1; i <= LAT; i++) begin
            tick();
            checks++;
            if (i < LAT && bus.rd_valid !== 1'b0) begin errors++;
                $display("FAIL read_early got rd_valid=%b expected 0", bus.rd_valid); end
            else if (i == LAT && {bus.rd_valid, bus.rd_data} !== {1'b1, 16'h1234}) begin errors++;
                $display("FAIL read_data got valid=%b data=%h expected 1 1234", bus.rd_valid, bus.rd_data); end
        end
        tick();
        checks++;
        if ({bus.rd_valid, bus.rd_data} !== {1'b0, 16'h1234}) begin errors++;
            $display("FAIL read_hold got valid=%b data=%h expected 0 1234", bus.rd_valid, bus.rd_data); end
    endtask

    task automatic test_frame();
        int          nw;
        logic [11:0] mask;
        do_reset();
        nw = 0; mask = '0;
        for (int i = 0; i < 15; i++) begin
            bus.wr_en = (i < 12);
            bus.wr_addr = 16'(16'h0200 + i); bus.wr_data = 16'($urandom);
            tick();
            if (bus.ram_we) begin
                nw++;
                if (bus.frame_done && nw <= 12) mask[nw-1] = 1'b1;
            end
            checks++;
            if (dut_vec() !== exp_vec()) begin errors++;
                $display("FAIL frame_vec cyc=%0d got=%h expected=%h", cyc, dut_vec(), exp_vec()); end
        end
        bus.wr_en = 0;
        checks++;
        if (nw != 12 || mask !== 12'b1000_1000_1000) begin errors++;
            $display("FAIL frame_done_pos got writes=%0d mask=%b expected 12 100010001000", nw, mask); end
    endtask

    task automatic test_reset_mid_read();
        bus.rd_req = 1; bus.rd_addr = 16'h0033;
        tick();
        bus.rd_req = 0;
        rst = 1'b1;
        #1;
        checks++;
        if (dut_vec() !== 54'd0) begin errors++;
            $display("FAIL midreset_outputs got=%h expected=0", dut_vec()); end
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.rd_valid !== 1'b0 || dut_vec() !== exp_vec()) begin errors++;
                $display("FAIL midreset_no_valid cyc=%0d got=%h expected=%h", cyc, dut_vec(), exp_vec()); end
        end
    endtask

    task automatic test_random();
        bit hold;
        do_reset();
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            bus.wr_en   = $urandom_range(0, 1);
            bus.wr_addr = 16'($urandom_range(0, 63));
            bus.wr_data = 16'($urandom);
            if (bus.rd_req && bus.rd_ack && !hold) begin
                bus.rd_req = 0;
            end else if (bus.rd_req && hold && $urandom_range(0, 3) == 0) begin
                bus.rd_req = 0; hold = 0;
            end else if (!bus.rd_req && $urandom_range(0, 2) == 0) begin
                bus.rd_req = 1;
                bus.rd_addr = 16'($urandom_range(0, 63));
                hold = ($urandom_range(0, 7) == 0);
            end
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin errors++;
                $display("FAIL random_vec cyc=%0d got=%h expected=%h", cyc, dut_vec(), exp_vec()); end
        end
        drive_idle();
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        test_reset();
        test_single_write();
        test_starvation();
        test_read_latency();
        test_overflow();
        test_frame();
        test_reset_mid_read();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-port image RAM between two requesters:
  - the UART image write stream (16-bit pixel words with write-enable pulses);
  - the TFT display read path.
- Buffers incoming writes in a small FIFO. Display reads have priority; a starvation counter forces writes through.
- Tracks completed frames (number of committed writes).
- Sits between the UART receive/assembly logic, the TFT controller and the RAM instance.

Parameters:
- AW, 16, RAM address width.
- DW, 16, RAM data width.
- WR_FIFO_DEPTH, 4, write buffer entries (power of two, minimum 2).
- MAX_WAIT, 8, cycles a pending write may lose to reads before it is forced.
- IMG_WORDS, 16384, words per frame; drives frame_done.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- wr_en  in  1  single-cycle write request
- wr_addr  in  AW  write address
- wr_data  in  DW  write data
- rd_req  in  1  read request, held until rd_ack
- rd_addr  in  AW  read address, stable while rd_req is high
- rd_ack  out  1  one-cycle pulse when the read command is issued
- rd_valid  out  1  one-cycle pulse when rd_data is valid
- rd_data  out  DW  read data
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_din  out  DW  RAM write data
- ram_dout  in  DW  RAM read data (synchronous, 1-cycle latency)
- wr_overflow  out  1  sticky flag: a write was dropped
- frame_done  out  1  one-cycle pulse on the last write of a frame

Behaviour:
- Reset values:
  - all outputs 0;
  - FIFO empty, wait_cnt 0, frame word counter 0, read-valid pipeline cleared.
- Reset mid-operation discards queued writes and in-flight reads. No rd_valid follows a reset.

Write FIFO:
- wr_en pushes {wr_addr, wr_data}.
- Push while full: entry is dropped and wr_overflow is set; it stays set until Reset.
- Push and pop in the same cycle while full: the push is accepted, because the pop frees the slot.

Arbitration:
- Evaluated every cycle from registered state. Grant order:
  1. FIFO non-empty and wait_cnt >= MAX_WAIT: grant write.
  2. rd_req high: grant read.
  3. FIFO non-empty: grant write.
  4. Otherwise idle.
- At most one grant per cycle.
- Read grant:
  - next cycle, ram_en=1, ram_we=0, ram_addr=rd_addr;
  - rd_ack=1 in that same cycle.
- Write grant:
  - pop the FIFO head;
  - next cycle, ram_en=1, ram_we=1, ram_addr/ram_din = head entry.
- Idle: ram_en=0, ram_we=0; ram_addr and ram_din hold their last values.
- A requester must drop rd_req the cycle after it sees rd_ack. A rd_req still high the cycle after rd_ack is treated as a new request.

wait_cnt:
- Increments, saturating at MAX_WAIT, on each cycle the FIFO is non-empty and no write is granted.
- Cleared on write grant and whenever the FIFO is empty.

Read data:
- rd_valid pulses exactly 1 cycle after the read command is on the ram_* ports.
- rd_data is registered from ram_dout and holds its value until the next rd_valid.

Frame counter:
- Increments on each issued write command. Dropped writes are not counted.
- When the counter equals IMG_WORDS-1 at issue time:
  - frame_done pulses together with that write command;
  - the counter wraps to 0.
- The counter is independent of wr_addr.

Throughput:
- Back-to-back reads: one per 2 cycles at most (the rd_ack handshake).
- Writes can drain one per cycle when no rd_req is pending.

Optional Feature:
- RAM_OUT_REG_EN defined:
  - the RAM instance uses its output register;
  - the rd_valid pipeline gains one stage, so rd_valid pulses 2 cycles after the read command.
- RAM_OUT_REG_EN undefined: latency is 1 cycle.
- Arbitration and FIFO behaviour are identical in both builds.

Decomposition:
- Shared package:
  - grant encoding constants GNT_NONE, GNT_RD, GNT_WR;
  - default AW, DW and IMG_WORDS values, shared with the UART image writer and the TFT controller.
- One sub-module: sync_wr_fifo.
  - Parameterised depth and width.
  - Full/empty flags, simultaneous push/pop.
  - Instantiated once for the write buffer.
- Arbitration, wait_cnt, frame counter and the read-valid pipeline stay in the top level.

Test Plan:
- Reset, then wr_en addr=0x0010 data=0xABCD with no reads -> 1 cycle later ram_en=1, ram_we=1, ram_addr=0x0010, ram_din=0xABCD.
- rd_req held continuously plus 1 write queued, MAX_WAIT=8 -> reads are granted for 8 arbitration cycles, then the write issues. wait_cnt clears, reads resume.
- 5 wr_en pulses on consecutive cycles while rd_req is held high (depth 4) -> 4 entries queued, the 5th dropped, wr_overflow=1 until Reset.
- rd_req addr=0x0100 with ram_dout=0x1234 -> rd_ack pulses with the command; rd_valid and rd_data=0x1234 arrive 1 cycle later, or 2 cycles later with RAM_OUT_REG_EN.
- IMG_WORDS=4, stream 9 writes -> frame_done pulses on the 4th and 8th issued writes, counter at 1 after the 9th.
- Reset asserted the cycle after a read command -> no rd_valid, FIFO empty, all outputs 0.
